// File: rtl/mux_rr_scheduler.sv
// Four-requester round-robin capture scheduler: grants one 8-bit word per cycle into a
// registered output slot, letting one requester hold the slot for up to BURST captures.
module mux_rr_scheduler #(
  parameter int unsigned BURST = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] grant_id,
  input  logic       out_ready
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [3:0] r_count, w_count_nxt;

  logic       w_load_en, w_any, w_keep, w_capture;
  logic [1:0] w_rr_win, w_sel;
  logic [7:0] w_sel_data;

  assign w_load_en = !out_valid || out_ready;
  assign w_any     = |req;
  assign w_keep    = (r_state == OWN) && req[r_owner] && (r_count < 4'(BURST));
  assign w_sel     = w_keep ? r_owner : w_rr_win;
  assign w_capture = w_load_en && w_any;
  assign gnt       = (w_capture && !rst) ? (4'b0001 << w_sel) : 4'b0000;

  // First active requester at or after the round-robin pointer, wrapping modulo 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_rr_win = r_ptr;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!found && req[idx]) begin
        w_rr_win = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    case (w_sel)
      2'd0:    w_sel_data = in0;
      2'd1:    w_sel_data = in1;
      2'd2:    w_sel_data = in2;
      default: w_sel_data = in3;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    if (w_load_en) begin
      if (!w_any) begin
        w_state_nxt = IDLE;
        w_count_nxt = 4'd0;
      end else if (w_keep) begin
        w_count_nxt = r_count + 4'd1;
      end else begin
        // A regrant of the same owner after its burst also lands here and restarts the count.
        w_owner_nxt = w_sel;
        w_count_nxt = 4'd1;
        w_ptr_nxt   = w_sel + 2'd1;
        w_state_nxt = OWN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= 2'd0;
      r_ptr     <= 2'd0;
      r_count   <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      grant_id  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      if (w_capture) begin
        out_valid <= 1'b1;
        out_data  <= w_sel_data;
        grant_id  <= w_sel;
      end else if (w_load_en) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
